// File: rtl/sram_wb_arbiter.sv
// rtl/sram_wb_arbiter.sv - two-master round-robin Wishbone arbiter in front of an SRAM controller
module sram_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    // master 0: data port
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    // master 1: instruction fetch port
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    // slave: SRAM controller
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    // debug: {state==GNT1, state==GNT0}
    output logic [1:0]  grant_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    // Counter value on the last granted cycle before the transfer is aborted.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;   // 0: master 0 was granted last, 1: master 1
    logic [7:0] count;

    logic       req0;
    logic       req1;
    logic       granted;
    logic       timeout_hit;
    logic       sel_m1;

    assign req0        = m0_cyc_i & m0_stb_i;
    assign req1        = m1_cyc_i & m1_stb_i;
    assign granted     = (state == GNT0) || (state == GNT1);
    assign timeout_hit = granted && (count == COUNT_LAST);

    // Next-state decision: IDLE arbitrates, a grant is held until ack or timeout.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    // Tie goes to the master that was not served last.
                    state_nxt = last_grant ? GNT0 : GNT1;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT0, GNT1: begin
                // The grant is not released when the owner drops cyc/stb;
                // only a slave ack or the timeout ends it.
                if (s_ack_i || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = state;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin history and granted-cycle counter, both reloaded on grant entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            count      <= 8'd0;
        end else if ((state == IDLE) && (state_nxt != IDLE)) begin
            last_grant <= (state_nxt == GNT1);
            count      <= 8'd0;
        end else if (granted && (state_nxt == state) && (count != 8'hff)) begin
            count <= count + 8'd1;
        end
    end

    // Error pulse: only a timeout exit without a coincident ack raises it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
        end else begin
            m0_err_o <= (state == GNT0) && timeout_hit && !s_ack_i;
            m1_err_o <= (state == GNT1) && timeout_hit && !s_ack_i;
        end
    end

    // Slave-side mux; IDLE keeps pointing at the last owner so the bus stays quiet.
    always_comb begin
        sel_m1 = (state == GNT1) || ((state == IDLE) && last_grant);
        if (sel_m1) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
        end else begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
        end
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
            end
            default: begin
                s_cyc_o = 1'b0;
                s_stb_o = 1'b0;
            end
        endcase
    end

    // Master-side responses: read data is broadcast, ack only reaches an active owner.
    always_comb begin
        m0_data_o = s_data_i;
        m1_data_o = s_data_i;
        m0_ack_o  = s_ack_i && (state == GNT0) && req0;
        m1_ack_o  = s_ack_i && (state == GNT1) && req1;
        grant_o   = {state == GNT1, state == GNT0};
    end

endmodule

// File: doc/sram_wb_arbiter.md
SRAM_WB_ARBITER -- requirements
Module: sram_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, means the number of granted cycles without s_ack before abort; legal range 2..255.
REQ-002 clk  input  1  system clock, max 50 MHz; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 m0_addr_i, m0_data_i  input  32 each  master 0 (data port) address and write data.
REQ-005 m0_we_i / m0_sel_i / m0_stb_i / m0_cyc_i  input  1/4/1/1  master 0 Wishbone controls.
REQ-006 m0_data_o  output  32  read data to master 0.
REQ-007 m0_ack_o / m0_err_o  output  1/1  master 0 acknowledge and error.
REQ-008 m1_* has the same set and widths as REQ-004..REQ-007; master 1 is the instruction fetch port.
REQ-009 s_addr_o, s_data_o  output  32 each  address and write data to the SRAM controller.
REQ-010 s_we_o / s_sel_o / s_stb_o / s_cyc_o  output  1/4/1/1  slave Wishbone controls.
REQ-011 s_data_i / s_ack_i  input  32/1  slave read data and acknowledge.
REQ-012 grant_o  output  2  debug; {state==GNT1, state==GNT0}.

Function
REQ-013 Master x requests when mx_cyc_i & mx_stb_i.
REQ-014 The FSM shall have three states: IDLE, GNT0 and GNT1.
REQ-015 IDLE transitions: one requester -> GNTx of that master; both requesting -> GNTx of the master not in last_grant (round-robin); none -> IDLE.
REQ-016 On entering GNTx, last_grant <= x and timeout counter <= 0.
REQ-017 GNTx exits to IDLE when s_ack_i=1 or when the counter equals TIMEOUT_CYCLES-1; otherwise it stays and the counter increments.
REQ-018 Once granted, a master's grant shall be held until ack or timeout, even if that master drops cyc/stb.
REQ-019 Arbitration latency: a request seen in IDLE at edge N drives s_stb_o=1 from edge N onward, i.e. one cycle after IDLE.
REQ-020 In GNTx, s_addr_o/s_data_o/s_we_o/s_sel_o shall be a combinational mux of master x, and s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i.
REQ-021 In IDLE, s_cyc_o=s_stb_o=0 and the data/address mux shall select last_grant.
REQ-022 The one IDLE cycle after every transfer guarantees the slave samples no request while it returns to its own idle state; back-to-back transfers to one master are therefore at least one cycle apart.
REQ-023 m0_data_o=m1_data_o=s_data_i at all times (broadcast).
REQ-024 mx_ack_o = s_ack_i & (state==GNTx) & mx_cyc_i & mx_stb_i, combinational; the ungranted master's ack shall be 0.
REQ-025 s_ack_i arriving in IDLE, or for a master that has withdrawn, shall be discarded.
REQ-026 mx_err_o shall be a registered one-cycle pulse on the edge where GNTx exits by timeout without s_ack_i.
REQ-027 If s_ack_i and the timeout occur on the same cycle, ack wins and no err is raised.
REQ-028 Simultaneous new requests in the same cycle as a GNT exit are evaluated in the following IDLE cycle, not in the exit cycle.
REQ-029 The counter shall be 8 bits and shall not wrap while granted.

Reset
REQ-030 While rst_n=0 at a clk edge: state=IDLE, last_grant=1 (master 0 wins the first tie), counter=0, m0_err_o=m1_err_o=0.
REQ-031 Consequently, during reset and the first cycle after it, s_cyc_o=s_stb_o=0 and all acks are 0.
REQ-032 Reset asserted mid-transfer shall abort the grant: slave strobes drop on the next edge, and a late s_ack_i is discarded.

Verification
REQ-033 M0 read of 0x00000010 only; slave acks 2 cycles after stb with data 0xDEADBEEF -> s_stb_o high 2 cycles, m0_ack_o one pulse with m0_data_o=0xDEADBEEF, m1_ack_o=0, then one IDLE cycle.
REQ-034 Both request from reset, each held until ack -> order M0, M1, M0, M1; grant_o sequence 01,00,10,00,01,...
REQ-035 M1 granted, M0 requests mid-transfer -> M0 is not granted until M1's ack plus one IDLE cycle; M1 sees no glitch on s_addr_o.
REQ-036 TIMEOUT_CYCLES=4 with slave never acking -> after exactly 4 granted cycles, m0_err_o pulses 1 cycle, state IDLE, a late s_ack_i is not forwarded.
REQ-037 s_ack_i coincides with the final timeout cycle -> m0_ack_o=1, m0_err_o=0.
REQ-038 rst_n low for one edge during GNT0 -> s_stb_o=0 the next cycle, last_grant=1; M0 is re-granted first after release.
